// File: rtl/uart_rx_fifo_if.sv
// Stream/bus bundle for the UART receive FIFO: RX-stage capture side, consumer
// valid/ready side and status. The FIFO connects through the slave modport.
interface uart_rx_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
);
   logic [DATA_WIDTH-1:0] rx_data_i;
   logic                  rx_done_i;
   logic [DATA_WIDTH-1:0] m_data_o;
   logic                  m_valid_o;
   logic                  m_ready_i;
   logic [ADDR_WIDTH:0]   level_o;
   logic                  empty_o;
   logic                  full_o;
   logic                  overrun_o;
   logic                  clr_overrun_i;

   modport slave (
      input  rx_data_i, rx_done_i, m_ready_i, clr_overrun_i,
      output m_data_o, m_valid_o, level_o, empty_o, full_o, overrun_o
   );

   modport master (
      output rx_data_i, rx_done_i, m_ready_i, clr_overrun_i,
      input  m_data_o, m_valid_o, level_o, empty_o, full_o, overrun_o
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART RX deserialiser: edge-detects rx_done, stores bytes
// in a first-word fall-through FIFO and flags dropped bytes with a sticky overrun bit.
module uart_rx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rstn,
   uart_rx_fifo_if.slave   bus
);
   localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic                  done_q;
   logic                  overrun_q, overrun_d;
   logic                  empty, full;
   logic                  push_req, pop, push, drop;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
      push_req = bus.rx_done_i & ~done_q;
      pop      = ~empty & bus.m_ready_i;
      // a pop in the same cycle frees the slot, so a full FIFO still accepts
      push     = push_req & (~full | pop);
      drop     = push_req & full & ~pop;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

      overrun_d = overrun_q;
      if (drop)                   overrun_d = 1'b1;
      else if (bus.clr_overrun_i) overrun_d = 1'b0;
   end

   // done_q resets high so a level already asserted at reset release is ignored
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         done_q    <= 1'b1;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         done_q    <= bus.rx_done_i;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.rx_data_i;
   end

   assign bus.level_o   = wr_ptr_q - rd_ptr_q;
   assign bus.empty_o   = empty;
   assign bus.full_o    = full;
   assign bus.m_valid_o = ~empty;
   assign bus.m_data_o  = empty ? '0 : mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
   assign bus.overrun_o = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_uart_rx_fifo;
   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   cmp_en   = 1'b0;

   uart_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

   uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   // reference model: a plain byte queue with a sticky loss flag
   logic [DW-1:0] mdl_q [$];
   bit            mdl_ov   = 1'b0;
   bit            mdl_prev = 1'b1;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mdl_q.delete();
         mdl_ov   = 1'b0;
         mdl_prev = 1'b1;
      end else begin
         bit new_frame, take, was_full, lost;
         new_frame = bus.rx_done_i && !mdl_prev;
         take      = bus.m_ready_i && (mdl_q.size() > 0);
         was_full  = (mdl_q.size() == DEPTH);
         lost      = 1'b0;
         if (take) void'(mdl_q.pop_front());
         if (new_frame) begin
            if (!was_full || take) mdl_q.push_back(bus.rx_data_i);
            else                   lost = 1'b1;
         end
         if (lost)                   mdl_ov = 1'b1;
         else if (bus.clr_overrun_i) mdl_ov = 1'b0;
         mdl_prev = bus.rx_done_i;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         int n;
         n = mdl_q.size();
         check("cmp_level", 32'(bus.level_o), 32'(n));
         check("cmp_empty", 32'(bus.empty_o), 32'(n == 0));
         check("cmp_full",  32'(bus.full_o),  32'(n == DEPTH));
         check("cmp_valid", 32'(bus.m_valid_o), 32'(n != 0));
         check("cmp_data",  32'(bus.m_data_o), (n != 0) ? 32'(mdl_q[0]) : 32'd0);
         check("cmp_ovr",   32'(bus.overrun_o), 32'(mdl_ov));
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_byte(input logic [DW-1:0] b);
      bus.rx_data_i = b;
      bus.rx_done_i = 1'b1;
      tick();
      bus.rx_done_i = 1'b0;
      tick();
   endtask

   initial begin
      bus.rx_data_i     = '0;
      bus.rx_done_i     = 1'b1;
      bus.m_ready_i     = 1'b0;
      bus.clr_overrun_i = 1'b0;
      #2 cmp_en = 1'b1;

      // 1: rx_done already high at reset release must not push
      tick(3);
      #2 rstn = 1'b1;
      tick(3);
      check("t1_level", 32'(bus.level_o), 32'd0);
      check("t1_valid", 32'(bus.m_valid_o), 32'd0);
      bus.rx_done_i = 1'b0;
      tick();

      // 2: long rx_done level gives a single push, visible one edge later
      bus.rx_data_i = 8'h41;
      bus.rx_done_i = 1'b1;
      tick();
      check("t2_level_first", 32'(bus.level_o), 32'd1);
      check("t2_data", 32'(bus.m_data_o), 32'h41);
      tick(9);
      check("t2_level_held", 32'(bus.level_o), 32'd1);
      bus.rx_done_i = 1'b0;
      bus.m_ready_i = 1'b1;
      tick();
      bus.m_ready_i = 1'b0;

      // 3: ordered delivery
      for (int i = 0; i < 4; i++) push_byte(8'(8'h41 + i));
      bus.m_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("t3_order", 32'(bus.m_data_o), 32'(8'h41 + i));
         tick();
      end
      bus.m_ready_i = 1'b0;
      check("t3_empty", 32'(bus.empty_o), 32'd1);

      // 4: overfill drops the 17th byte and sets overrun
      for (int i = 0; i < 17; i++) push_byte(8'(i));
      check("t4_full", 32'(bus.full_o), 32'd1);
      check("t4_level", 32'(bus.level_o), 32'd16);
      check("t4_ovr", 32'(bus.overrun_o), 32'd1);
      bus.m_ready_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("t4_drain", 32'(bus.m_data_o), 32'(i));
         tick();
      end
      bus.m_ready_i = 1'b0;
      check("t4_empty", 32'(bus.empty_o), 32'd1);
      check("t4_ovr_kept", 32'(bus.overrun_o), 32'd1);
      bus.clr_overrun_i = 1'b1;
      tick();
      bus.clr_overrun_i = 1'b0;
      check("t4_ovr_clr", 32'(bus.overrun_o), 32'd0);

      // 5: push coinciding with pop on a full FIFO is accepted
      for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
      check("t5_full", 32'(bus.full_o), 32'd1);
      bus.rx_data_i = 8'h30;
      bus.rx_done_i = 1'b1;
      bus.m_ready_i = 1'b1;
      tick();
      bus.rx_done_i = 1'b0;
      bus.m_ready_i = 1'b0;
      check("t5_level", 32'(bus.level_o), 32'd16);
      check("t5_ovr", 32'(bus.overrun_o), 32'd0);
      check("t5_head", 32'(bus.m_data_o), 32'h21);
      tick();
      bus.m_ready_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("t5_drain", 32'(bus.m_data_o), 32'(8'h21 + i));
         tick();
      end
      bus.m_ready_i = 1'b0;

      // 6: asynchronous reset mid-stream, then random traffic
      for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i));
      check("t6_level5", 32'(bus.level_o), 32'd5);
      #3 rstn = 1'b0;
      #1;
      check("t6_rst_level", 32'(bus.level_o), 32'd0);
      check("t6_rst_empty", 32'(bus.empty_o), 32'd1);
      check("t6_rst_valid", 32'(bus.m_valid_o), 32'd0);
      check("t6_rst_data", 32'(bus.m_data_o), 32'd0);
      check("t6_rst_full", 32'(bus.full_o), 32'd0);
      tick(2);
      #2 rstn = 1'b1;
      tick();

      for (int c = 0; c < 1500; c++) begin
         int rdy_pct;
         rdy_pct = (c < 500) ? 20 : (c < 1000) ? 80 : 50;
         if (bus.rx_done_i) begin
            if ($urandom_range(0, 1) == 1) bus.rx_done_i = 1'b0;
         end else if ($urandom_range(0, 1) == 1) begin
            bus.rx_data_i = 8'($urandom);
            bus.rx_done_i = 1'b1;
         end
         bus.m_ready_i     = ($urandom_range(0, 99) < rdy_pct);
         bus.clr_overrun_i = ($urandom_range(0, 15) == 0);
         tick();
      end
      bus.rx_done_i     = 1'b0;
      bus.m_ready_i     = 1'b0;
      bus.clr_overrun_i = 1'b0;
      tick(2);
      cmp_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
